// File: rtl/conv_pkg.sv
// Shared encodings and width helpers for the convolution line buffer.
package conv_pkg;

  localparam logic [0:0] LB_WR_FILL  = 1'b0;
  localparam logic [0:0] LB_WR_WAIT  = 1'b1;

  localparam logic [1:0] LB_RD_IDLE  = 2'd0;
  localparam logic [1:0] LB_RD_PASS  = 2'd1;
  localparam logic [1:0] LB_RD_DRAIN = 2'd2;

  // Bits needed to index n items, never less than one.
  function automatic int lb_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Single-step modulo for ring pointers where v < 2*n.
  function automatic int lb_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/lb_bank.sv
// One row bank: simple dual-port RAM with a registered read port.
module lb_bank
  import conv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer_ring.sv
// Row-window line buffer over ROWS+1 rotating banks; emits one ROWS-tall column per handshake.
// Optional feature: define LB_FLUSH_EN to add the flush port.
module line_buffer_ring
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int ROWS          = 3,
  parameter int MAX_ROW_WIDTH = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef LB_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic [31:0]                  row_width,
  input  logic [BUS_WIDTH-1:0]         s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [ROWS*DATA_WIDTH-1:0]   m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [$clog2(ROWS+2)-1:0]    rows_valid,
  output logic                         cfg_err
);

  localparam int PIX_PER_WORD = BUS_WIDTH / DATA_WIDTH;
  localparam int NUM_BANKS    = ROWS + 1;
  localparam int ADDR_WIDTH   = $clog2(MAX_ROW_WIDTH);
  localparam int XW           = ADDR_WIDTH + 1;
  localparam int DEPTH        = (MAX_ROW_WIDTH + PIX_PER_WORD - 1) / PIX_PER_WORD;
  localparam int WAW          = lb_width(DEPTH);
  localparam int BW           = lb_width(NUM_BANKS);
  localparam int SW           = lb_width(PIX_PER_WORD);
  localparam int RVW          = $clog2(NUM_BANKS + 1);
  localparam int LW           = ROWS * DATA_WIDTH;

  logic                 flush_s;
  logic                 ready_en_r;
  logic [XW-1:0]        cfg_width_r;
  logic                 cfg_err_r;
  logic [0:0]           wr_state_r;
  logic [XW-1:0]        wr_x_r;
  logic [WAW-1:0]       wr_word_r;
  logic [BW-1:0]        wr_bank_r;
  logic [RVW-1:0]       rows_valid_r;
  logic [RVW-1:0]       rows_valid_next_s;
  logic [1:0]           rd_state_r;
  logic [XW-1:0]        rd_x_r;
  logic [WAW-1:0]       rd_word_r;
  logic [SW-1:0]        rd_sel_r;
  logic [BW-1:0]        rd_base_r;
  logic                 v1_r;
  logic                 last1_r;
  logic [SW-1:0]        sel1_r;
  logic [LW-1:0]        m_data_r;
  logic                 m_valid_r;
  logic                 m_last_r;
  logic [LW-1:0]        skid_data_r;
  logic                 skid_last_r;
  logic                 skid_valid_r;

  logic                 s_ready_s;
  logic                 accept_s;
  logic                 latch_s;
  logic                 bad_width_s;
  logic [XW:0]          wr_sum_s;
  logic                 row_done_s;
  logic                 pop_s;
  logic [1:0]           occ_s;
  logic [1:0]           limit_s;
  logic                 issue_s;
  logic                 rd_is_last_s;
  logic                 retire_s;
  logic                 load_head_s;
  logic [LW-1:0]        in_data_s;
  logic [BUS_WIDTH-1:0] bank_q [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_pix_s [NUM_BANKS];

`ifdef LB_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign s_ready_s   = ready_en_r & (wr_state_r == LB_WR_FILL) & ~cfg_err_r;
  assign accept_s    = s_valid & s_ready_s & ~flush_s;
  assign latch_s     = (rows_valid_r == RVW'(0)) & (wr_x_r == XW'(0));
  assign bad_width_s = (row_width == 32'd0) || (row_width > 32'(MAX_ROW_WIDTH));
  assign wr_sum_s    = {1'b0, wr_x_r} + (XW+1)'(PIX_PER_WORD);
  assign row_done_s  = accept_s & (wr_sum_s >= {1'b0, cfg_width_r});

  // Issue only while the in-flight beat plus buffered beats fit the 2-entry output buffer.
  assign pop_s        = m_valid_r & m_ready;
  assign occ_s        = {1'b0, m_valid_r} + {1'b0, skid_valid_r} + {1'b0, v1_r};
  assign limit_s      = 2'd1 + {1'b0, pop_s};
  assign issue_s      = (rd_state_r == LB_RD_PASS) & (occ_s <= limit_s);
  assign rd_is_last_s = ((rd_x_r + XW'(1)) == cfg_width_r);
  assign retire_s     = (rd_state_r == LB_RD_DRAIN) & pop_s & m_last_r;
  assign load_head_s  = ~m_valid_r | pop_s;

  // Occupancy update; a completion and a retire in the same cycle cancel.
  always_comb begin
    rows_valid_next_s = rows_valid_r;
    case ({row_done_s, retire_s})
      2'b10:   rows_valid_next_s = rows_valid_r + RVW'(1);
      2'b01:   rows_valid_next_s = rows_valid_r - RVW'(1);
      default: rows_valid_next_s = rows_valid_r;
    endcase
  end

  // Width configuration and the one-cycle post-reset input hold-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en_r  <= 1'b0;
      cfg_width_r <= '0;
      cfg_err_r   <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (latch_s) begin
        cfg_width_r <= row_width[XW-1:0];
        cfg_err_r   <= bad_width_s;
      end else begin
        cfg_width_r <= cfg_width_r;
        cfg_err_r   <= cfg_err_r;
      end
    end
  end

  // Write FSM: fills the bank after the newest complete row, waits when every bank is full.
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      wr_state_r <= LB_WR_FILL;
      wr_x_r     <= '0;
      wr_word_r  <= '0;
      wr_bank_r  <= '0;
    end else begin
      case (wr_state_r)
        LB_WR_FILL: begin
          if (row_done_s) begin
            wr_x_r    <= '0;
            wr_word_r <= '0;
            wr_bank_r <= (wr_bank_r == BW'(NUM_BANKS-1)) ? BW'(0) : wr_bank_r + BW'(1);
          end else if (accept_s) begin
            wr_x_r    <= wr_sum_s[XW-1:0];
            wr_word_r <= wr_word_r + WAW'(1);
          end else begin
            wr_x_r    <= wr_x_r;
          end
          wr_state_r <= (rows_valid_next_s == RVW'(NUM_BANKS)) ? LB_WR_WAIT : LB_WR_FILL;
        end
        LB_WR_WAIT: begin
          wr_state_r <= retire_s ? LB_WR_FILL : LB_WR_WAIT;
        end
        default: wr_state_r <= LB_WR_FILL;
      endcase
    end
  end

  // Completed-row count.
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      rows_valid_r <= '0;
    end else begin
      rows_valid_r <= rows_valid_next_s;
    end
  end

  // Read FSM: one pass over the window per ROWS complete rows, retiring the oldest row at the end.
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      rd_state_r <= LB_RD_IDLE;
      rd_x_r     <= '0;
      rd_word_r  <= '0;
      rd_sel_r   <= '0;
      rd_base_r  <= '0;
    end else begin
      case (rd_state_r)
        LB_RD_IDLE: begin
          rd_state_r <= (rows_valid_r >= RVW'(ROWS)) ? LB_RD_PASS : LB_RD_IDLE;
        end
        LB_RD_PASS: begin
          if (issue_s && rd_is_last_s) begin
            rd_state_r <= LB_RD_DRAIN;
            rd_x_r     <= '0;
            rd_word_r  <= '0;
            rd_sel_r   <= '0;
          end else if (issue_s) begin
            rd_x_r <= rd_x_r + XW'(1);
            if (rd_sel_r == SW'(PIX_PER_WORD-1)) begin
              rd_sel_r  <= '0;
              rd_word_r <= rd_word_r + WAW'(1);
            end else begin
              rd_sel_r  <= rd_sel_r + SW'(1);
            end
          end else begin
            rd_state_r <= LB_RD_PASS;
          end
        end
        LB_RD_DRAIN: begin
          if (retire_s) begin
            rd_state_r <= LB_RD_IDLE;
            rd_base_r  <= (rd_base_r == BW'(NUM_BANKS-1)) ? BW'(0) : rd_base_r + BW'(1);
          end else begin
            rd_state_r <= LB_RD_DRAIN;
          end
        end
        default: rd_state_r <= LB_RD_IDLE;
      endcase
    end
  end

  // Tags travelling alongside the BRAM read.
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      v1_r    <= 1'b0;
      last1_r <= 1'b0;
      sel1_r  <= '0;
    end else begin
      v1_r    <= issue_s;
      last1_r <= rd_is_last_s;
      sel1_r  <= rd_sel_r;
    end
  end

  // Pixel slice of each bank word, then rotate banks into lanes (lane 0 = oldest row).
  always_comb begin
    in_data_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_pix_s[b] = '0;
      for (int p = 0; p < PIX_PER_WORD; p++) begin
        bank_pix_s[b] = (sel1_r == SW'(p)) ? bank_q[b][p*DATA_WIDTH +: DATA_WIDTH] : bank_pix_s[b];
      end
    end
    for (int i = 0; i < ROWS; i++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        in_data_s[i*DATA_WIDTH +: DATA_WIDTH] =
          (BW'(b) == BW'(lb_wrap(int'(rd_base_r) + i, NUM_BANKS))) ?
          bank_pix_s[b] : in_data_s[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output head register plus skid entry; head holds steady while stalled.
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      m_data_r     <= '0;
      m_valid_r    <= 1'b0;
      m_last_r     <= 1'b0;
      skid_data_r  <= '0;
      skid_last_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (load_head_s && skid_valid_r) begin
      m_data_r     <= skid_data_r;
      m_last_r     <= skid_last_r;
      m_valid_r    <= 1'b1;
      skid_valid_r <= v1_r;
      if (v1_r) begin
        skid_data_r <= in_data_s;
        skid_last_r <= last1_r;
      end else begin
        skid_data_r <= skid_data_r;
      end
    end else if (load_head_s) begin
      m_valid_r <= v1_r;
      m_last_r  <= v1_r & last1_r;
      if (v1_r) begin
        m_data_r <= in_data_s;
      end else begin
        m_data_r <= m_data_r;
      end
    end else if (v1_r) begin
      skid_data_r  <= in_data_s;
      skid_last_r  <= last1_r;
      skid_valid_r <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    lb_bank #(
      .WIDTH (BUS_WIDTH),
      .DEPTH (DEPTH),
      .AW    (WAW)
    ) u_bank (
      .clk   (clk),
      .we    (accept_s & (wr_bank_r == BW'(b))),
      .waddr (wr_word_r),
      .wdata (s_data),
      .raddr (rd_word_r),
      .rdata (bank_q[b])
    );
  end

  assign s_ready    = s_ready_s;
  assign m_data     = m_data_r;
  assign m_valid    = m_valid_r;
  assign m_last     = m_last_r;
  assign rows_valid = rows_valid_r;
  assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_line_buffer_ring.sv
// Scoreboard bench for line_buffer_ring (ROWS=3, 8-bit pixels, 32-bit bus).
module tb_line_buffer_ring;

  localparam int ROWS = 3;
  localparam int RVW  = $clog2(ROWS + 2);

  logic             clk;
  logic             rst;
  logic             flush_b;
  logic [31:0]      row_width;
  logic [31:0]      s_data;
  logic             s_valid;
  logic             s_ready;
  logic [23:0]      m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [RVW-1:0]   rows_valid;
  logic             cfg_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [24:0] exp_q[$];
  logic rand_mode = 1'b0;
  logic t2_on = 1'b0;
  int t2_bad = 0;
  int t2_full = 0;
  logic held_v = 1'b0;
  logic [24:0] held;

  line_buffer_ring dut (
    .clk        (clk),
    .rst        (rst),
`ifdef LB_FLUSH_EN
    .flush      (flush_b),
`endif
    .row_width  (row_width),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .rows_valid (rows_valid),
    .cfg_err    (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int x);
    return 8'((r * 16 + x) & 255);
  endfunction

  task automatic push_pass(input int base, input int w);
    logic [24:0] e;
    for (int x = 0; x < w; x++) begin
      e = '0;
      e[24] = (x == w - 1);
      for (int l = 0; l < ROWS; l++) e[l*8 +: 8] = pix(base + l, x);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int w);
    rst = 1'b1;
    s_valid = 1'b0;
    row_width = w;
    repeat (2) tick();
    exp_q.delete();
    rst = 1'b0;
  endtask

  // Sends one row; pixels beyond w in the last word are filler that must never appear.
  task automatic send_row(input int r, input int w);
    logic ok;
    logic [31:0] word;
    for (int wd = 0; wd < (w + 3) / 4; wd++) begin
      for (int p = 0; p < 4; p++) word[p*8 +: 8] = (wd*4 + p < w) ? pix(r, wd*4 + p) : 8'hEE;
      s_data = word;
      s_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
        @(negedge clk);
        ok = s_ready;
        tick();
      end
      check("s_ready_wait", 32'(ok), 32'd1);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check(name, exp_q.size(), 32'd0);
    tick();
  endtask

  // Sink-side ready pattern.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expected beats on each handshake, checks hold stability while stalled.
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (rst || flush_b) begin
        held_v = 1'b0;
      end else begin
        if (held_v) check("m_stable", {m_valid, m_last, m_data}, {1'b1, held});
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h expected none", {m_last, m_data});
          end else begin
            e = exp_q.pop_front();
            check("m_beat", {m_last, m_data}, e);
          end
        end
        held_v = m_valid && !m_ready;
        held = {m_last, m_data};
      end
    end
  end

  // Backpressure monitor for the 5-row stream: s_ready must be low exactly when all banks hold rows.
  initial begin
    forever begin
      @(negedge clk);
      if (t2_on && !rst) begin
        if (s_ready == (rows_valid == RVW'(4))) t2_bad++;
        if (!s_ready && rows_valid == RVW'(4)) t2_full++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush_b = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    row_width = 32'd8;

    // 1: reset state, one pass over rows 0..2
    do_reset(8);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rows_valid", 32'(rows_valid), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    tick();
    @(negedge clk);
    check("ready_after_hold", 32'(s_ready), 32'd1);
    tick();
    push_pass(0, 8);
    for (int r = 0; r < 3; r++) send_row(r, 8);
    @(negedge clk);
    check("t1_rows_full", 32'(rows_valid), 32'd3);
    tick();
    wait_drain("t1_drain");
    repeat (3) tick();
    @(negedge clk);
    check("t1_rows_after", 32'(rows_valid), 32'd2);
    check("t1_m_valid_idle", 32'(m_valid), 32'd0);
    tick();

    // 2: five rows streamed, three passes
    do_reset(8);
    tick();
    t2_on = 1'b1;
    for (int p = 0; p < 3; p++) push_pass(p, 8);
    for (int r = 0; r < 5; r++) send_row(r, 8);
    wait_drain("t2_drain");
    t2_on = 1'b0;
    check("t2_bad_ready", t2_bad, 32'd0);
    check("t2_full_seen", 32'(t2_full != 0), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    check("t2_rows_after", 32'(rows_valid), 32'd2);
    tick();

    // 3: width 6, partial final word
    do_reset(6);
    tick();
    push_pass(0, 6);
    for (int r = 0; r < 3; r++) send_row(r, 6);
    wait_drain("t3_drain");

    // 4: random backpressure over four passes
    do_reset(8);
    tick();
    rand_mode = 1'b1;
    for (int p = 0; p < 4; p++) push_pass(p, 8);
    for (int r = 0; r < 6; r++) send_row(r, 8);
    wait_drain("t4_drain");
    rand_mode = 1'b0;
    tick();

    // 5: illegal widths then recovery
    do_reset(0);
    repeat (3) tick();
    @(negedge clk);
    check("t5_err_zero", 32'(cfg_err), 32'd1);
    check("t5_ready_zero", 32'(s_ready), 32'd0);
    tick();
    row_width = 32'd2000;
    repeat (2) tick();
    @(negedge clk);
    check("t5_err_big", 32'(cfg_err), 32'd1);
    tick();
    row_width = 32'd8;
    repeat (2) tick();
    @(negedge clk);
    check("t5_err_clear", 32'(cfg_err), 32'd0);
    check("t5_ready_back", 32'(s_ready), 32'd1);
    tick();
    push_pass(0, 8);
    for (int r = 0; r < 3; r++) send_row(r, 8);
    wait_drain("t5_drain");

    // 6: abort mid-pass, then refill
    do_reset(8);
    tick();
    push_pass(0, 8);
    for (int r = 0; r < 3; r++) send_row(r, 8);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() <= 5) break;
    end
    check("t6_reach_col3", 32'(exp_q.size() <= 5), 32'd1);
`ifdef LB_FLUSH_EN
    flush_b = 1'b1;
`else
    rst = 1'b1;
`endif
    exp_q.delete();
    @(negedge clk);
    check("t6_m_valid", 32'(m_valid), 32'd0);
    check("t6_rows_valid", 32'(rows_valid), 32'd0);
    flush_b = 1'b0;
    rst = 1'b0;
    tick();
    push_pass(0, 8);
    for (int r = 0; r < 3; r++) send_row(r, 8);
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
